// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile-board constants, shuffler state enum and draw mask helper
//
// Purpose: common definitions for the board shuffler and the tile RAM byte layout.
// Ports: none (package).
package tile_pkg;

  localparam int NUM_TILES   = 16;
  localparam int NUM_PAIRS   = 8;

  // Tile byte layout: [7:2] pair id, [1] flipped, [0] cursor
  localparam int TILE_ID_LSB = 2;
  localparam int FLIP_BIT    = 1;
  localparam int CURSOR_BIT  = 0;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHUFFLE,
    S_WRITE,
    S_DONE
  } shufState_t;

  // Smallest 2^n-1 covering i, so a masked 4-bit draw can reach every index 0..i
  // while rejecting as few draws as possible.
  function automatic logic [3:0] drawMask(input logic [3:0] i);
    if (i >= 4'd8)      return 4'hF;
    else if (i >= 4'd4) return 4'h7;
    else if (i >= 4'd2) return 4'h3;
    else                return 4'h1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with synchronous load and advance enable
//
// Purpose: pseudo-random source for the board shuffle.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset, loads RESET_SEED
//   load     in   load seed (has priority over advance)
//   seed     in   16-bit load value
//   advance  in   shift one step this cycle
//   q        out  current LFSR state
module lfsr16
  import tile_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_SEED;
    end else if (load) begin
      q <= seed;
    end else if (advance) begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/board_shuffler.sv
// rtl/board_shuffler.sv - builds, shuffles and writes a 4x4 board of 8 tile pairs
//
// Purpose: on a start rising edge, fill 16 tiles with pair ids, Fisher-Yates
// shuffle them using an LFSR, write all 16 bytes to the tile RAM, then raise
// board_ready.
// Optional build macro: SHUFFLER_FREE_RUN_EN (LFSR free-runs from reset, never reloaded).
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-high reset
//   start        in   level; rising edge requests a new board (IDLE only)
//   we           out  tile RAM write enable
//   addr         out  tile RAM address (4 bits)
//   wdata        out  tile byte {pair id, flipped, cursor}
//   busy         out  high while filling, shuffling or writing
//   done         out  one-cycle pulse after the last write
//   board_ready  out  level, high from done until next accepted start or reset
module board_shuffler
  import tile_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       we,
  output logic [3:0] addr,
  output logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       board_ready
);

  // An all-zero Galois LFSR would lock up, so zero falls back to the default seed.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  localparam int ID_W = $clog2(NUM_PAIRS);

  shufState_t state, nextState;

  logic            startPrev;
  logic            startEdge;
  logic            accept;
  logic [ID_W-1:0] arr [NUM_TILES];
  logic [3:0]      i;
  logic [3:0]      k;
  logic [3:0]      r;
  logic            swapOk;
  logic [15:0]     lfsrQ;
  logic            lfsrLoad;
  logic            lfsrAdvance;
  logic [7:0]      tileByte;
  logic            unusedLfsrHi;

  assign startEdge    = start & ~startPrev;
  assign r            = lfsrQ[3:0] & drawMask(i);
  assign swapOk       = (r <= i);
  assign unusedLfsrHi = ^lfsrQ[15:4];

`ifdef SHUFFLER_FREE_RUN_EN
  assign lfsrLoad    = 1'b0;
  assign lfsrAdvance = 1'b1;
`else
  assign lfsrLoad    = accept;
  assign lfsrAdvance = (state == S_SHUFFLE);
`endif

  lfsr16 #(.RESET_SEED(SEED_EFF)) uLfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsrLoad),
    .seed    (SEED_EFF),
    .advance (lfsrAdvance),
    .q       (lfsrQ)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (startEdge) begin
          nextState = S_FILL;
          accept    = 1'b1;
        end
      end
      S_FILL:    nextState = S_SHUFFLE;
      S_SHUFFLE: if (swapOk && (i == 4'd1)) nextState = S_WRITE;
      S_WRITE:   if (k == 4'd15) nextState = S_DONE;
      S_DONE:    nextState = S_IDLE;
      default:   nextState = S_IDLE;
    endcase
  end

  // Board array and shuffle/write indices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startPrev <= 1'b0;
      i         <= 4'd15;
      k         <= 4'd0;
      for (int t = 0; t < NUM_TILES; t++) arr[t] <= '0;
    end else begin
      startPrev <= start;
      case (state)
        S_FILL: begin
          for (int t = 0; t < NUM_TILES; t++) arr[t] <= ID_W'(t >> 1);
          i <= 4'd15;
        end
        S_SHUFFLE: begin
          // Rejected draws (r > i) leave the board untouched; only the LFSR moves.
          if (swapOk) begin
            arr[i] <= arr[r];
            arr[r] <= arr[i];
            i      <= i - 4'd1;
            if (i == 4'd1) k <= 4'd0;
          end
        end
        S_WRITE: k <= k + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    tileByte                       = '0;
    tileByte[TILE_ID_LSB +: ID_W]  = arr[k];
    tileByte[FLIP_BIT]             = 1'b0;
    tileByte[CURSOR_BIT]           = (k == 4'd0);
  end

  // Registered outputs; all write-port signals update on the same edge, and
  // done/board_ready only rise on the edge after the final write has retired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we          <= 1'b0;
      addr        <= 4'd0;
      wdata       <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      board_ready <= 1'b0;
    end else begin
      we   <= (state == S_WRITE);
      busy <= (state == S_FILL) || (state == S_SHUFFLE) || (state == S_WRITE);
      done <= (state == S_DONE);
      if (state == S_WRITE) begin
        addr  <= k;
        wdata <= tileByte;
      end
      if (accept)                board_ready <= 1'b0;
      else if (state == S_DONE)  board_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_board_shuffler.sv
// tb/tb_board_shuffler.sv - self-checking bench for board_shuffler
module tb_board_shuffler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       we, busy, done, board_ready;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       weZ, busyZ, doneZ, readyZ;
  logic [3:0] addrZ;
  logic [7:0] wdataZ;

  board_shuffler #(.SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .board_ready(board_ready)
  );

  board_shuffler #(.SEED(16'h0000)) dutZ (
    .clk(clk), .reset(reset), .start(start), .we(weZ), .addr(addrZ), .wdata(wdataZ),
    .busy(busyZ), .done(doneZ), .board_ready(readyZ)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  int nWr, nWrZ, nDone, nDoneZ, nBusyRise, busyCnt, overlap;
  logic busyPrev = 1'b0;
  logic [3:0] wrAddr  [32];
  logic [7:0] wrData  [32];
  logic [7:0] wrDataZ [32];
  logic [7:0] golden  [16];
  int goldenDraws;

  typedef struct {
    int hold;
    int glitch;
    int expWrites;
    int expDone;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain Fisher-Yates over an int array, rejection sampling with the
  // smallest all-ones mask covering i, LFSR stepped once per draw.
  task automatic buildGolden(input logic [15:0] seed);
    int a[16];
    logic [15:0] l;
    int ii, m, rr, tmp, draws;
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    for (int t = 0; t < 16; t++) a[t] = t / 2;
    ii = 15;
    draws = 0;
    while (ii >= 1) begin
      m = 1;
      while (m < ii) m = 2 * m + 1;
      rr = (int'(l) % 16) & m;
      draws++;
      if (rr <= ii) begin
        tmp = a[ii]; a[ii] = a[rr]; a[rr] = tmp;
        ii--;
      end
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
    for (int t = 0; t < 16; t++) golden[t] = 8'(a[t] * 4 + ((t == 0) ? 1 : 0));
    goldenDraws = draws;
  endtask

  always @(negedge clk) begin
    if (we) begin
      if (nWr < 32) begin wrAddr[nWr] = addr; wrData[nWr] = wdata; end
      nWr++;
    end
    if (weZ) begin
      if (nWrZ < 32) wrDataZ[nWrZ] = wdataZ;
      nWrZ++;
    end
    if (done)  nDone++;
    if (doneZ) nDoneZ++;
    if ((done || board_ready) && we) overlap++;
    if (busy) busyCnt++;
    if (busy && !busyPrev) nBusyRise++;
    busyPrev = busy;
  end

  task automatic clearCounters();
    nWr = 0; nWrZ = 0; nDone = 0; nDoneZ = 0; nBusyRise = 0; busyCnt = 0; overlap = 0;
    for (int j = 0; j < 32; j++) begin
      wrAddr[j] = 'x; wrData[j] = 'x; wrDataZ[j] = 'x;
    end
  endtask

  task automatic runScenario(input vec_t v, input int idx);
    int lat;
    int idCnt[8];
    logic pairOk;
    clearCounters();
    lat = -1;
    @(negedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= v.hold + 90; c++) begin
      @(negedge clk); #1;
      if (c == v.hold) start = 1'b0;
      if (v.glitch >= 0 && c == v.glitch) start = 1'b1;
      if (v.glitch >= 0 && c == v.glitch + 1) start = 1'b0;
      if (c == 2) check($sformatf("v%0d ready_cleared", idx), board_ready, 0);
      if (done && lat < 0) lat = c;
    end
    start = 1'b0;
    check($sformatf("v%0d write_count", idx), nWr, v.expWrites);
    check($sformatf("v%0d done_count", idx), nDone, v.expDone);
    check($sformatf("v%0d busy_rises", idx), nBusyRise, 1);
    check($sformatf("v%0d busy_cycles", idx), busyCnt, 17 + goldenDraws);
    check($sformatf("v%0d done_we_overlap", idx), overlap, 0);
    check($sformatf("v%0d latency", idx), lat, 19 + goldenDraws);
    check($sformatf("v%0d board_ready", idx), board_ready, 1);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("v%0d addr[%0d]", idx, j), wrAddr[j], j);
      check($sformatf("v%0d data[%0d]", idx, j), wrData[j], golden[j]);
    end
    pairOk = 1'b1;
    for (int p = 0; p < 8; p++) idCnt[p] = 0;
    for (int j = 0; j < 16; j++) begin
      if (wrData[j][1] !== 1'b0) pairOk = 1'b0;
      if (wrData[j][0] !== ((j == 0) ? 1'b1 : 1'b0)) pairOk = 1'b0;
      if (wrData[j][7:5] !== 3'b000) pairOk = 1'b0;
      else idCnt[wrData[j][4:2]]++;
    end
    for (int p = 0; p < 8; p++) if (idCnt[p] != 2) pairOk = 1'b0;
    check($sformatf("v%0d pair_layout", idx), pairOk, 1);
    check($sformatf("v%0d seed0_writes", idx), nWrZ, 16);
    check($sformatf("v%0d seed0_done", idx), nDoneZ, 1);
    for (int j = 0; j < 16; j++)
      check($sformatf("v%0d seed0_data[%0d]", idx, j), wrDataZ[j], golden[j]);
  endtask

  initial begin
    int found;
    reset = 1'b1;
    start = 1'b0;
    buildGolden(16'hACE1);
    repeat (3) @(negedge clk);
    #1;
    check("rst we", we, 0);
    check("rst addr", addr, 0);
    check("rst wdata", wdata, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst board_ready", board_ready, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    tbl[0] = '{1, -1, 16, 1};
    tbl[1] = '{1, -1, 16, 1};
    tbl[2] = '{100, -1, 16, 1};
    tbl[3] = '{1, 5, 16, 1};
    tbl[4] = '{2, 12, 16, 1};
    for (int n = 5; n < 8; n++) begin
      tbl[n].hold      = $urandom_range(1, 60);
      tbl[n].glitch    = $urandom_range(3, 25);
      if (tbl[n].glitch <= tbl[n].hold) tbl[n].glitch = -1;
      tbl[n].expWrites = 16;
      tbl[n].expDone   = 1;
    end

    for (int n = 0; n < 8; n++) runScenario(tbl[n], n);

    // Reset in the middle of WRITE, right after the addr=5 write is on the port
    clearCounters();
    found = 0;
    @(negedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk); #1;
      if (c == 1) start = 1'b0;
      if (we && addr == 4'd5) begin found = 1; break; end
    end
    check("midrst reached_addr5", found, 1);
    reset = 1'b1;
    #1;
    check("midrst we", we, 0);
    check("midrst busy", busy, 0);
    check("midrst board_ready", board_ready, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    check("midrst no_done", nDone, 0);
    check("midrst partial_writes", nWr, 6);
    repeat (2) @(negedge clk);
    runScenario(tbl[0], 99);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
